// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the memory arbiter slice.
package memory_arbiter_pkg;

    localparam int REGSIZE = 8;

    typedef logic [REGSIZE-1:0] DEFAULT_TYPE;

    typedef enum logic [1:0] {
        MEMORY_STAY  = 2'b00,
        MEMORY_READ  = 2'b01,
        MEMORY_WRITE = 2'b10
    } MEMORY_FLAG_TYPE;

    // Sequencer states kept as plain constants so older code can compare raw bits
    typedef logic [1:0] ARBITER_STATE_TYPE;
    localparam ARBITER_STATE_TYPE ARB_IDLE    = 2'd0;
    localparam ARBITER_STATE_TYPE ARB_ISSUE   = 2'd1;
    localparam ARBITER_STATE_TYPE ARB_RESPOND = 2'd2;

    typedef logic PORT_ID_TYPE;
    localparam PORT_ID_TYPE PORT_CPU    = 1'b0;
    localparam PORT_ID_TYPE PORT_LOADER = 1'b1;

endpackage

// File: rtl/memory_arbiter_round_robin_select.sv
// Two-port round-robin picker: a lone request wins, a tie goes to the port
// that did not win last time.
module round_robin_select
    import memory_arbiter_pkg::*;
(
    input  logic        REQ0,
    input  logic        REQ1,
    input  PORT_ID_TYPE last_grant,
    output logic        valid,
    output PORT_ID_TYPE winner
);

    // Pick the winner among the currently raised requests
    always_comb begin
        valid  = REQ0 | REQ1;
        winner = PORT_CPU;
        if (REQ0 && REQ1) begin
            winner = ~last_grant;
        end else if (REQ1) begin
            winner = PORT_LOADER;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one memory_unit port between the cpu core (port 0) and the
// program loader / debug port (port 1) with an IDLE -> ISSUE -> RESPOND
// sequencer, round-robin tie breaking and a saturating conflict counter.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = REGSIZE,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  CLOCK,
    input  logic                  RESET_N,
    input  logic                  REQ0,
    input  logic                  REQ1,
    input  MEMORY_FLAG_TYPE       RW0,
    input  MEMORY_FLAG_TYPE       RW1,
    input  logic [DATA_WIDTH-1:0] ADDR0,
    input  logic [DATA_WIDTH-1:0] ADDR1,
    input  logic [DATA_WIDTH-1:0] WDATA0,
    input  logic [DATA_WIDTH-1:0] WDATA1,
    output logic                  ACK0,
    output logic                  ACK1,
    output logic [DATA_WIDTH-1:0] RDATA0,
    output logic [DATA_WIDTH-1:0] RDATA1,
    output logic [DATA_WIDTH-1:0] address,
    output MEMORY_FLAG_TYPE       rw_flag,
    output logic [DATA_WIDTH-1:0] write_memory_value,
    input  logic [DATA_WIDTH-1:0] read_memory_value,
    output logic                  BUSY,
    output logic [CNT_WIDTH-1:0]  CONFLICT_COUNT
);

    ARBITER_STATE_TYPE state;
    PORT_ID_TYPE       grant;
    PORT_ID_TYPE       last_grant;
    logic              sel_valid;
    PORT_ID_TYPE       sel_winner;

    round_robin_select u_round_robin_select (
        .REQ0       (REQ0),
        .REQ1       (REQ1),
        .last_grant (last_grant),
        .valid      (sel_valid),
        .winner     (sel_winner)
    );

    assign BUSY = (state != ARB_IDLE);

    // Sequencer: register the winner's request, capture read data, pulse the ack
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state              <= ARB_IDLE;
            grant              <= PORT_CPU;
            last_grant         <= PORT_LOADER;
            ACK0               <= 1'b0;
            ACK1               <= 1'b0;
            RDATA0             <= '0;
            RDATA1             <= '0;
            address            <= '0;
            rw_flag            <= MEMORY_STAY;
            write_memory_value <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (sel_valid) begin
                        grant      <= sel_winner;
                        last_grant <= sel_winner;
                        if (sel_winner == PORT_LOADER) begin
                            address            <= ADDR1;
                            rw_flag            <= RW1;
                            write_memory_value <= WDATA1;
                        end else begin
                            address            <= ADDR0;
                            rw_flag            <= RW0;
                            write_memory_value <= WDATA0;
                        end
                        state <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (rw_flag == MEMORY_READ) begin
                        if (grant == PORT_LOADER) begin
                            RDATA1 <= read_memory_value;
                        end else begin
                            RDATA0 <= read_memory_value;
                        end
                    end
                    if (grant == PORT_LOADER) begin
                        ACK1 <= 1'b1;
                    end else begin
                        ACK0 <= 1'b1;
                    end
                    address            <= '0;
                    rw_flag            <= MEMORY_STAY;
                    write_memory_value <= '0;
                    state              <= ARB_RESPOND;
                end
                ARB_RESPOND: begin
                    ACK0  <= 1'b0;
                    ACK1  <= 1'b0;
                    state <= ARB_IDLE;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    // Count idle cycles where both ports want the memory, sticking at all-ones
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            CONFLICT_COUNT <= '0;
        end else if (state == ARB_IDLE && REQ0 && REQ1 && CONFLICT_COUNT != '1) begin
            CONFLICT_COUNT <= CONFLICT_COUNT + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed testbench for memory_arbiter with a small behavioural memory.
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    logic            CLOCK = 1'b0;
    logic            RESET_N;
    logic            REQ0, REQ1;
    MEMORY_FLAG_TYPE RW0, RW1;
    logic [7:0]      ADDR0, ADDR1, WDATA0, WDATA1;
    logic            ACK0, ACK1, BUSY;
    logic [7:0]      RDATA0, RDATA1, address, write_memory_value, read_memory_value;
    MEMORY_FLAG_TYPE rw_flag;
    logic [7:0]      CONFLICT_COUNT;

    logic            satAck0, satAck1, satBusy;
    logic [7:0]      satRdata0, satRdata1, satAddress, satWriteValue;
    MEMORY_FLAG_TYPE satRwFlag;
    logic [1:0]      satCount;

    logic [7:0]      mem [256];
    logic            preloadEn;
    logic [7:0]      preloadAddr, preloadData;

    int compared   = 0;
    int mismatched = 0;

    always #5 CLOCK = ~CLOCK;

    memory_arbiter #(.DATA_WIDTH(8), .CNT_WIDTH(8)) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N),
        .REQ0(REQ0), .REQ1(REQ1), .RW0(RW0), .RW1(RW1),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .ACK0(ACK0), .ACK1(ACK1), .RDATA0(RDATA0), .RDATA1(RDATA1),
        .address(address), .rw_flag(rw_flag), .write_memory_value(write_memory_value),
        .read_memory_value(read_memory_value), .BUSY(BUSY), .CONFLICT_COUNT(CONFLICT_COUNT)
    );

    memory_arbiter #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dutSat (
        .CLOCK(CLOCK), .RESET_N(RESET_N),
        .REQ0(REQ0), .REQ1(REQ1), .RW0(RW0), .RW1(RW1),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .ACK0(satAck0), .ACK1(satAck1), .RDATA0(satRdata0), .RDATA1(satRdata1),
        .address(satAddress), .rw_flag(satRwFlag), .write_memory_value(satWriteValue),
        .read_memory_value(8'h00), .BUSY(satBusy), .CONFLICT_COUNT(satCount)
    );

    // Memory model: combinational read, write commits at the edge closing the write cycle
    assign read_memory_value = mem[address];

    // Memory write port, with a side door for preloading contents
    always @(posedge CLOCK) begin
        if (rw_flag == MEMORY_WRITE) begin
            mem[address] <= write_memory_value;
        end else if (preloadEn) begin
            mem[preloadAddr] <= preloadData;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic applyStimulus(input int port, input logic req, input MEMORY_FLAG_TYPE rw,
                                 input logic [7:0] addr, input logic [7:0] wdata);
        if (port == 0) begin
            REQ0 = req; RW0 = rw; ADDR0 = addr; WDATA0 = wdata;
        end else begin
            REQ1 = req; RW1 = rw; ADDR1 = addr; WDATA1 = wdata;
        end
    endtask

    task automatic waitAck(input int port, input int budget, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if ((port == 0 ? ACK0 : ACK1) === 1'b1) seen = 1'b1;
        end
        checkOutput(tag, 32'(seen), 32'd1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ack0"},  32'(ACK0), 32'd0);
        checkOutput({tag, "_ack1"},  32'(ACK1), 32'd0);
        checkOutput({tag, "_rd0"},   32'(RDATA0), 32'd0);
        checkOutput({tag, "_rd1"},   32'(RDATA1), 32'd0);
        checkOutput({tag, "_addr"},  32'(address), 32'd0);
        checkOutput({tag, "_rw"},    32'(rw_flag), 32'(MEMORY_STAY));
        checkOutput({tag, "_wval"},  32'(write_memory_value), 32'd0);
        checkOutput({tag, "_busy"},  32'(BUSY), 32'd0);
        checkOutput({tag, "_count"}, 32'(CONFLICT_COUNT), 32'd0);
    endtask

    initial begin
        int ack0Pulses;
        int ack1Pulses;

        RESET_N = 1'b0;
        applyStimulus(0, 1'b0, MEMORY_STAY, 8'h00, 8'h00);
        applyStimulus(1, 1'b0, MEMORY_STAY, 8'h00, 8'h00);
        preloadEn = 1'b1; preloadAddr = 8'h10; preloadData = 8'h5A;
        #2;
        checkResetValues("reset_init");
        tick();
        preloadEn = 1'b0;
        tick();
        RESET_N = 1'b1;
        tick();

        // Single read on port 0
        applyStimulus(0, 1'b1, MEMORY_READ, 8'h10, 8'h00);
        tick();
        checkOutput("rd_issue_addr", 32'(address), 32'h10);
        checkOutput("rd_issue_rw",   32'(rw_flag), 32'(MEMORY_READ));
        checkOutput("rd_issue_busy", 32'(BUSY), 32'd1);
        checkOutput("rd_issue_ack0", 32'(ACK0), 32'd0);
        tick();
        checkOutput("rd_ack0",       32'(ACK0), 32'd1);
        checkOutput("rd_rdata0",     32'(RDATA0), 32'h5A);
        checkOutput("rd_ack1",       32'(ACK1), 32'd0);
        checkOutput("rd_addr_idle",  32'(address), 32'h00);
        checkOutput("rd_rw_idle",    32'(rw_flag), 32'(MEMORY_STAY));
        applyStimulus(0, 1'b0, MEMORY_STAY, 8'h00, 8'h00);
        tick();
        checkOutput("rd_ack0_drop",  32'(ACK0), 32'd0);
        checkOutput("rd_busy_drop",  32'(BUSY), 32'd0);
        checkOutput("rd_rdata_hold", 32'(RDATA0), 32'h5A);

        // Write on port 1, then read it back on port 0
        applyStimulus(1, 1'b1, MEMORY_WRITE, 8'h20, 8'hC3);
        tick();
        checkOutput("wr_issue_addr", 32'(address), 32'h20);
        checkOutput("wr_issue_rw",   32'(rw_flag), 32'(MEMORY_WRITE));
        checkOutput("wr_issue_wval", 32'(write_memory_value), 32'hC3);
        tick();
        checkOutput("wr_ack1",       32'(ACK1), 32'd1);
        checkOutput("wr_ack0",       32'(ACK0), 32'd0);
        checkOutput("wr_mem",        32'(mem[8'h20]), 32'hC3);
        checkOutput("wr_wval_idle",  32'(write_memory_value), 32'h00);
        applyStimulus(1, 1'b0, MEMORY_STAY, 8'h00, 8'h00);
        tick();
        applyStimulus(0, 1'b1, MEMORY_READ, 8'h20, 8'h00);
        waitAck(0, 6, "rbw_ack0");
        checkOutput("rbw_rdata0",    32'(RDATA0), 32'hC3);
        applyStimulus(0, 1'b0, MEMORY_STAY, 8'h00, 8'h00);
        tick();

        // STAY access: full sequence, still acked, read data untouched
        applyStimulus(0, 1'b1, MEMORY_STAY, 8'h10, 8'h77);
        tick();
        checkOutput("stay_rw",       32'(rw_flag), 32'(MEMORY_STAY));
        checkOutput("stay_busy",     32'(BUSY), 32'd1);
        waitAck(0, 4, "stay_ack0");
        checkOutput("stay_rdata0",   32'(RDATA0), 32'hC3);
        applyStimulus(0, 1'b0, MEMORY_STAY, 8'h00, 8'h00);
        tick();

        // Contention from reset release, both requests held
        RESET_N = 1'b0;
        applyStimulus(0, 1'b1, MEMORY_READ, 8'h10, 8'h00);
        applyStimulus(1, 1'b1, MEMORY_READ, 8'h20, 8'h00);
        tick();
        RESET_N = 1'b1;
        ack0Pulses = 0;
        ack1Pulses = 0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (ACK0 === 1'b1) ack0Pulses++;
            if (ACK1 === 1'b1) ack1Pulses++;
            if (k == 1) begin
                checkOutput("ct_count1",  32'(CONFLICT_COUNT), 32'd1);
                checkOutput("ct_addr0",   32'(address), 32'h10);
            end
            if (k == 2) begin
                checkOutput("ct_ack0_t2", 32'(ACK0), 32'd1);
                checkOutput("ct_ack1_t2", 32'(ACK1), 32'd0);
                checkOutput("ct_rdata0",  32'(RDATA0), 32'h5A);
            end
            if (k == 4) begin
                checkOutput("ct_count2",  32'(CONFLICT_COUNT), 32'd2);
                checkOutput("ct_addr1",   32'(address), 32'h20);
            end
            if (k == 5) begin
                checkOutput("ct_ack1_t5", 32'(ACK1), 32'd1);
                checkOutput("ct_ack0_t5", 32'(ACK0), 32'd0);
                checkOutput("ct_rdata1",  32'(RDATA1), 32'hC3);
            end
            if (k == 7) checkOutput("ct_count3", 32'(CONFLICT_COUNT), 32'd3);
            if (k == 8) checkOutput("ct_ack0_t8", 32'(ACK0), 32'd1);
            if (k == 10) checkOutput("sat_count_t10", 32'(satCount), 32'd3);
            if (k == 13) begin
                checkOutput("ct_count5",     32'(CONFLICT_COUNT), 32'd5);
                checkOutput("sat_count_t13", 32'(satCount), 32'd3);
            end
        end
        checkOutput("ct_ack0_pulses", 32'(ack0Pulses), 32'd3);
        checkOutput("ct_ack1_pulses", 32'(ack1Pulses), 32'd2);
        applyStimulus(0, 1'b0, MEMORY_STAY, 8'h00, 8'h00);
        applyStimulus(1, 1'b0, MEMORY_STAY, 8'h00, 8'h00);
        tick();

        // Port 1 read to load RDATA1, then reset during the ISSUE of the next read
        applyStimulus(1, 1'b1, MEMORY_READ, 8'h10, 8'h00);
        waitAck(1, 6, "pre_ack1");
        checkOutput("pre_rdata1", 32'(RDATA1), 32'h5A);
        applyStimulus(1, 1'b0, MEMORY_STAY, 8'h00, 8'h00);
        tick();
        applyStimulus(1, 1'b1, MEMORY_READ, 8'h20, 8'h00);
        tick();
        checkOutput("abort_issue_addr", 32'(address), 32'h20);
        #2;
        RESET_N = 1'b0;
        #1;
        checkResetValues("abort");
        tick();
        checkOutput("abort_no_ack1", 32'(ACK1), 32'd0);
        RESET_N = 1'b1;
        waitAck(1, 6, "reissue_ack1");
        checkOutput("reissue_rdata1", 32'(RDATA1), 32'hC3);
        applyStimulus(1, 1'b0, MEMORY_STAY, 8'h00, 8'h00);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Shares the single `memory_unit` port between two requesters: port 0 (cpu core, req/ack revision) and port 1 (program loader / debug access). Each access passes through a three-state sequencer that registers the memory address, rw flag and write value, captures read data, and returns a one-cycle acknowledge. Round-robin selection on conflict; a saturating conflict counter feeds the debug view.

## Interface
- `DATA_WIDTH`, 8 (`REGSIZE`), width of data and address words.
- `CNT_WIDTH`, 8, width of the conflict counter.
- `CLOCK`  in  1  sole clock, rising edge.
- `RESET_N`  in  1  asynchronous, active-low reset.
- `REQ0`, `REQ1`  in  1  access request, level, held until ack.
- `RW0`, `RW1`  in  `MEMORY_FLAG_TYPE`  `MEMORY_READ` / `MEMORY_WRITE` / `MEMORY_STAY`.
- `ADDR0`, `ADDR1`  in  DATA_WIDTH  access address.
- `WDATA0`, `WDATA1`  in  DATA_WIDTH  write data.
- `ACK0`, `ACK1`  out  1  one-cycle completion pulse.
- `RDATA0`, `RDATA1`  out  DATA_WIDTH  read data, valid while ACKn=1, held until next ack on that port.
- `address`  out  DATA_WIDTH  to memory_unit.
- `rw_flag`  out  `MEMORY_FLAG_TYPE`  to memory_unit.
- `write_memory_value`  out  DATA_WIDTH  to memory_unit.
- `read_memory_value`  in  DATA_WIDTH  from memory_unit, valid in the cycle the registered address/flag are presented.
- `BUSY`  out  1  state != ARB_IDLE.
- `CONFLICT_COUNT`  out  CNT_WIDTH  cycles in ARB_IDLE with both REQs high, saturating.

## Operation
- States: ARB_IDLE, ARB_ISSUE, ARB_RESPOND. Sequence always IDLE -> ISSUE -> RESPOND -> IDLE.
- ARB_IDLE: no REQ -> stay; one REQ -> grant it; both -> grant port != `last_grant`. On grant: register winner's ADDR/RW/WDATA onto `address`/`rw_flag`/`write_memory_value`, set `grant`, `last_grant <= grant`, go ISSUE.
- ARB_ISSUE: memory outputs held; memory commits write at the closing edge; `read_memory_value` captured into RDATA[grant] if RW was `MEMORY_READ` (else RDATA unchanged). Outputs return to idle values (address 0, `MEMORY_STAY`, write value 0) at the closing edge. Go RESPOND.
- ARB_RESPOND: ACK[grant]=1, other ACK=0. REQ inputs ignored this cycle. Go IDLE.
- RW=`MEMORY_STAY` with REQ high: full sequence, no memory effect, still acked.
- Requester must hold REQ/RW/ADDR/WDATA stable from assertion through ack; REQ still high in the IDLE cycle after ack is a new request (back-to-back allowed).
- Conflict counter: +1 per IDLE cycle with REQ0&REQ1, saturates at all-ones, no wrap.

## Timing
- Reset (RESET_N low, asynchronous): state ARB_IDLE, `last_grant`=1 (port 0 wins first tie), ACK0/1=0, RDATA0/1=0, address=0, write_memory_value=0, rw_flag=`MEMORY_STAY`, BUSY=0, CONFLICT_COUNT=0. Release sampled synchronously at next rising edge.
- Reset mid-access: access aborted, no ack; a write already committed at an ISSUE closing edge stays committed; requester reissues.
- Latency: REQ sampled high in IDLE at cycle T -> memory outputs valid cycle T+1 -> ACK and RDATA cycle T+2. Throughput one access per 3 cycles; uncontested port never waits more than one foreign access (≤ 5 cycles REQ-to-ACK under contention).
- No combinational path from REQ/ADDR/RW/WDATA to any output; all outputs registered.

## Structure
- Add to `typedef_collection.sv`: `ARBITER_STATE_TYPE` (ARB_IDLE, ARB_ISSUE, ARB_RESPOND), `PORT_ID_TYPE` (1 bit). Reuse `DEFAULT_TYPE`, `MEMORY_FLAG_TYPE`.
- One combinational sub-module `round_robin_select` (inputs REQ0, REQ1, last_grant; outputs valid, winner). Everything else in `memory_arbiter`.

## Test plan
- Reset: RESET_N low mid-run -> all outputs at reset values immediately, before any clock edge.
- Single read: mem[0x10]=0x5A, REQ0 RW=READ ADDR=0x10 at T -> address=0x10 rw_flag=READ at T+1, ACK0=1 RDATA0=0x5A at T+2, ACK1 never.
- Single write then read: REQ1 WRITE 0x20<-0xC3, after ACK1 REQ0 READ 0x20 -> RDATA0=0xC3.
- Contention: REQ0, REQ1 both high from reset release -> ACK0 at T+2, ACK1 at T+5, ACK0 again at T+8 if held; CONFLICT_COUNT=1 after first IDLE, increments each contended IDLE.
- Saturation: CNT_WIDTH=2, 5 contended IDLE cycles -> CONFLICT_COUNT stays 3.
- Reset in ISSUE of a READ on port 1 -> no ACK1, RDATA1=0, next access after release served normally.
